// File: rtl/bpsk_transmitter.sv
// bpsk_transmitter: byte-serial BPSK baseband modulator driving an 8-bit DAC (6-sample carrier, 1 = inverted phase).
// Define TX_PREAMBLE_EN to prefix each frame with the PREAMBLE byte.
`default_nettype none

module bpsk_transmitter #(
  parameter int CARRIERS_PER_BIT = 15,
`ifdef TX_PREAMBLE_EN
  parameter logic [7:0] PREAMBLE = 8'h55,
`endif
  parameter int GAP_CYCLES = 720
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] transmitter_da,
  output logic       transmitter_sync_out
);

  localparam int C_CW = (CARRIERS_PER_BIT > 1) ? $clog2(CARRIERS_PER_BIT) : 1;
  localparam int C_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [C_CW-1:0] C_CMAX = C_CW'(CARRIERS_PER_BIT - 1);
  localparam logic [C_GW-1:0] C_GMAX = C_GW'(GAP_CYCLES - 1);
  localparam logic [7:0] C_IDLE = 8'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_PRE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_p, w_p_nxt;
  logic [C_CW-1:0] r_c, w_c_nxt;
  logic [2:0]      r_b, w_b_nxt;
  logic [C_GW-1:0] r_g, w_g_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic [7:0]      r_da;
  logic            r_sync;
  logic            w_last;
  logic            w_ready_raw;
  logic            w_burst_nxt;
  logic [7:0]      w_da_nxt;

  function automatic logic [7:0] f_sample(input logic bit_v, input logic [2:0] ph);
    logic [7:0] v;
    case ({bit_v, ph})
      4'b0_001, 4'b0_010: v = 8'h6D;
      4'b0_100, 4'b0_101: v = 8'h93;
      4'b1_001, 4'b1_010: v = 8'h93;
      4'b1_100, 4'b1_101: v = 8'h6D;
      default:            v = C_IDLE;
    endcase
    return v;
  endfunction

  assign w_last = (r_p == 3'd5) && (r_c == C_CMAX) && (r_b == 3'd7);

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_c_nxt     = r_c;
    w_b_nxt     = r_b;
    w_g_nxt     = r_g;
    w_byte_nxt  = r_byte;
    w_ready_raw = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef TX_PREAMBLE_EN
        // A pending byte triggers the preamble first; the byte itself is taken at its end.
        if (tx_valid) begin
          w_state_nxt = S_PRE;
          w_byte_nxt  = PREAMBLE;
          w_p_nxt     = 3'd0;
          w_c_nxt     = '0;
          w_b_nxt     = 3'd0;
        end
`else
        w_ready_raw = 1'b1;
        if (tx_valid) begin
          w_state_nxt = S_SEND;
          w_byte_nxt  = tx_data;
          w_p_nxt     = 3'd0;
          w_c_nxt     = '0;
          w_b_nxt     = 3'd0;
        end
`endif
      end
      S_SEND, S_PRE: begin
        if (w_last) begin
          w_ready_raw = 1'b1;
          w_p_nxt     = 3'd0;
          w_c_nxt     = '0;
          w_b_nxt     = 3'd0;
          if (tx_valid) begin
            w_state_nxt = S_SEND;
            w_byte_nxt  = tx_data;
          end else begin
            w_state_nxt = S_GAP;
            w_g_nxt     = '0;
          end
        end else if (r_p == 3'd5) begin
          w_p_nxt = 3'd0;
          if (r_c == C_CMAX) begin
            w_c_nxt = '0;
            w_b_nxt = r_b + 3'd1;
          end else begin
            w_c_nxt = r_c + C_CW'(1);
          end
        end else begin
          w_p_nxt = r_p + 3'd1;
        end
      end
      S_GAP: begin
        if (r_g == C_GMAX) begin
          w_state_nxt = S_IDLE;
          w_g_nxt     = '0;
        end else begin
          w_g_nxt = r_g + C_GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next-state view so sample 0 appears right after the accept edge.
  assign w_burst_nxt = (w_state_nxt == S_SEND) || (w_state_nxt == S_PRE);
  assign w_da_nxt    = w_burst_nxt ? f_sample(w_byte_nxt[w_b_nxt], w_p_nxt) : C_IDLE;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_p     <= 3'd0;
      r_c     <= '0;
      r_b     <= 3'd0;
      r_g     <= '0;
      r_byte  <= 8'h00;
      r_da    <= C_IDLE;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_c     <= w_c_nxt;
      r_b     <= w_b_nxt;
      r_g     <= w_g_nxt;
      r_byte  <= w_byte_nxt;
      r_da    <= w_da_nxt;
      r_sync  <= w_burst_nxt;
    end
  end

  assign tx_ready             = w_ready_raw & resetN;
  assign transmitter_da       = r_da;
  assign transmitter_sync_out = r_sync;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_transmitter.sv
// tb_bpsk_transmitter: scoreboard bench for bpsk_transmitter; expected samples are queued as bytes are offered.
`default_nettype none

module tb_bpsk_transmitter;

`ifdef TX_PREAMBLE_EN
  localparam bit C_PRE = 1'b1;
`else
  localparam bit C_PRE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] transmitter_da;
  logic       transmitter_sync_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Each entry: {tx_ready, sync, da}
  logic [9:0] exp_q[$];
  logic [7:0] tbl0[6] = '{8'h7F, 8'h6D, 8'h6D, 8'h7F, 8'h93, 8'h93};
  logic [7:0] tbl1[6] = '{8'h7F, 8'h93, 8'h93, 8'h7F, 8'h6D, 8'h6D};

  always #5 clock = ~clock;

  bpsk_transmitter dut (
    .clock               (clock),
    .resetN              (resetN),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .transmitter_da      (transmitter_da),
    .transmitter_sync_out(transmitter_sync_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 90; k++)
        exp_q.push_back({(j == 7 && k == 89), 1'b1, (v[j] ? tbl1[k % 6] : tbl0[k % 6])});
  endtask

  task automatic test_reset();
    resetN = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    n_cmp++;
    if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
      n_bad++;
      $display("FAIL reset_state got=%h want=%h", {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
    end
    resetN = 1'b1;
    tick();
    n_cmp++;
    if (tx_ready !== !C_PRE) begin
      n_bad++;
      $display("FAIL reset_release_ready got=%b want=%b", tx_ready, !C_PRE);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 1000; i++) begin
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {!C_PRE, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL idle cyc=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {!C_PRE, 1'b0, 8'h7F});
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [9:0] e;
    tx_data = 8'h00; tx_valid = 1'b1; push_byte(8'h00);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 720; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL single_00 s=%0d got=%h want=%h", k, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      tick();
    end
    for (int i = 0; i < 720; i++) begin
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL single_gap g=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
      end
      tick();
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready_after_gap got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[6];
    logic [7:0] rx;
    logic [9:0] e;
    int idx;
    int cnt;
    int s;
    bytes = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hF0, 8'h0F};
    rx = 8'h00;
    cnt = 0;
    tx_data = bytes[0]; tx_valid = 1'b1; push_byte(bytes[0]); idx = 1;
    tick();
    tx_valid = 1'b0;
    while (exp_q.size() > 0 && cnt < 6 * 720) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL b2b s=%0d got=%h want=%h", cnt, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      s = cnt % 720;
      if (s % 90 == 1) rx[s / 90] = (transmitter_da == 8'h93);
      if (s == 719) begin
        n_cmp++;
        if (rx !== bytes[cnt / 720]) begin
          n_bad++;
          $display("FAIL b2b_demod byte=%0d got=%h want=%h", cnt / 720, rx, bytes[cnt / 720]);
        end
      end
      if (e[9] && idx < 6) begin
        tx_data = bytes[idx]; tx_valid = 1'b1; push_byte(bytes[idx]); idx++;
      end
      tick();
      tx_valid = 1'b0;
      cnt++;
    end
    n_cmp++;
    if (cnt != 6 * 720) begin
      n_bad++;
      $display("FAIL b2b_length got=%0d want=%0d", cnt, 6 * 720);
    end
    for (int i = 0; i < 720; i++) begin
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL b2b_gap g=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
      end
      tick();
    end
  endtask

  task automatic test_gap_wait();
    logic [9:0] e;
    tx_data = 8'h3C; tx_valid = 1'b1; push_byte(8'h3C);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 720; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL gapwait_3c s=%0d got=%h want=%h", k, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      tick();
    end
    for (int i = 0; i < 720; i++) begin
      if (i == 100) begin
        tx_data = 8'hC3; tx_valid = 1'b1;
      end
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL gapwait_gap g=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
      end
      tick();
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL gapwait_ready got=%b want=1", tx_ready);
    end
    push_byte(8'hC3);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 720; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL gapwait_c3 s=%0d got=%h want=%h", k, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      tick();
    end
    for (int i = 0; i < 720; i++) begin
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL gapwait_gap2 g=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
      end
      tick();
    end
  endtask

  task automatic test_reset_midbyte();
    logic [9:0] e;
    tx_data = 8'h0F; tx_valid = 1'b1; push_byte(8'h0F);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k <= 300; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL rstmid_0f s=%0d got=%h want=%h", k, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      if (k < 300) tick();
    end
    exp_q.delete();
    resetN = 1'b0;
    tick();
    n_cmp++;
    if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
      n_bad++;
      $display("FAIL rstmid_in_reset got=%h want=%h", {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
    end
    resetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b1, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL rstmid_after c=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b1, 1'b0, 8'h7F});
      end
    end
  endtask

  task automatic test_preamble();
    logic [9:0] e;
    tx_data = 8'hAA; tx_valid = 1'b1;
    push_byte(8'h55);
    push_byte(8'hAA);
    tick();
    for (int k = 0; k < 1440; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== e) begin
        n_bad++;
        $display("FAIL preamble s=%0d got=%h want=%h", k, {tx_ready, transmitter_sync_out, transmitter_da}, e);
      end
      tick();
      if (k == 719) tx_valid = 1'b0;
    end
    for (int i = 0; i < 720; i++) begin
      n_cmp++;
      if ({tx_ready, transmitter_sync_out, transmitter_da} !== {1'b0, 1'b0, 8'h7F}) begin
        n_bad++;
        $display("FAIL preamble_gap g=%0d got=%h want=%h", i, {tx_ready, transmitter_sync_out, transmitter_da}, {1'b0, 1'b0, 8'h7F});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    if (C_PRE) begin
      test_preamble();
    end else begin
      test_single();
      test_back_to_back();
      test_gap_wait();
      test_reset_midbyte();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
